// File: rtl/regfile_rename_pkg.sv
// ============================================================================
// regfile_rename_pkg : shared constants and helpers for the renaming regfile
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_rename_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_TAG_W = 4;
  localparam int TAG_NONE  = 0;

  function automatic int reg_idx_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_src_mux.sv
// ============================================================================
// regfile_src_mux : operand value/tag priority selection for one source
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_src_mux
  import regfile_rename_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W,
  parameter int N_CDB = 2
) (
  input  logic                    slot_valid_i,
  input  logic                    src_zero_i,
  input  logic                    grp_hit_i,
  input  logic [TAG_W-1:0]        grp_tag_i,
  input  logic [TAG_W-1:0]        dep_i,
  input  logic                    spec_rdy_i,
  input  logic [XLEN-1:0]         spec_val_i,
  input  logic [XLEN-1:0]         arch_i,
  input  logic [N_CDB-1:0]        cdb_valid_i,
  input  logic [N_CDB*TAG_W-1:0]  cdb_tag_i,
  input  logic [N_CDB*XLEN-1:0]   cdb_val_i,
  input  logic                    cmt_valid_i,
  input  logic [TAG_W-1:0]        cmt_tag_i,
  input  logic [XLEN-1:0]         cmt_val_i,
  output logic [XLEN-1:0]         v_o,
  output logic [TAG_W-1:0]        q_o
);

  localparam logic [TAG_W-1:0] c_tag_none = TAG_W'(TAG_NONE);

  logic            w_cdb_hit;
  logic [XLEN-1:0] w_cdb_v;

  always_comb begin
    v_o       = '0;
    q_o       = c_tag_none;
    w_cdb_hit = 1'b0;
    w_cdb_v   = '0;
    // Descending scan so the lowest matching channel is the one left standing
    for (int c = N_CDB - 1; c >= 0; c--) begin
      if (cdb_valid_i[c] && cdb_tag_i[c*TAG_W +: TAG_W] == dep_i) begin
        w_cdb_hit = 1'b1;
        w_cdb_v   = cdb_val_i[c*XLEN +: XLEN];
      end
    end

    if (!slot_valid_i || src_zero_i) begin
      v_o = '0;
      q_o = c_tag_none;
    end else if (grp_hit_i) begin
      q_o = grp_tag_i;
    end else if (dep_i == c_tag_none) begin
      v_o = arch_i;
    end else if (spec_rdy_i) begin
      v_o = spec_val_i;
    end else if (w_cdb_hit) begin
      v_o = w_cdb_v;
    end else if (cmt_valid_i && cmt_tag_i == dep_i) begin
      v_o = cmt_val_i;
    end else begin
      q_o = dep_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_rename.sv
// ============================================================================
// regfile_rename : multi-issue architectural regfile with rename tags and
//                  CDB-filled speculative value buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREG    = DEF_NREG,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int N_ISSUE = 2,
  parameter int N_CDB   = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  rdy_in,
  input  logic [N_ISSUE-1:0]                    iss_valid,
  input  logic [N_ISSUE*reg_idx_w(NREG)-1:0]    iss_rd,
  input  logic [N_ISSUE*reg_idx_w(NREG)-1:0]    iss_rs1,
  input  logic [N_ISSUE*reg_idx_w(NREG)-1:0]    iss_rs2,
  input  logic [N_ISSUE*TAG_W-1:0]              iss_tag,
  input  logic [N_CDB-1:0]                      cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]                cdb_tag,
  input  logic [N_CDB*XLEN-1:0]                 cdb_val,
  input  logic                                  cmt_valid,
  input  logic [reg_idx_w(NREG)-1:0]            cmt_rd,
  input  logic [TAG_W-1:0]                      cmt_tag,
  input  logic [XLEN-1:0]                       cmt_val,
  input  logic                                  flush,
  output logic [N_ISSUE*XLEN-1:0]               vj,
  output logic [N_ISSUE*XLEN-1:0]               vk,
  output logic [N_ISSUE*TAG_W-1:0]              qj,
  output logic [N_ISSUE*TAG_W-1:0]              qk
);

  localparam int               RW         = reg_idx_w(NREG);
  localparam logic [TAG_W-1:0] c_tag_none = TAG_W'(TAG_NONE);

  logic [XLEN-1:0]  arch_q [NREG];
  logic [XLEN-1:0]  arch_d [NREG];
  logic [TAG_W-1:0] dep_q  [NREG];
  logic [TAG_W-1:0] dep_d  [NREG];
  logic [XLEN-1:0]  sval_q [NREG];
  logic [XLEN-1:0]  sval_d [NREG];
  logic [NREG-1:0]  srdy_q;
  logic [NREG-1:0]  srdy_d;

  logic             w_cdb_hit;
  logic [XLEN-1:0]  w_cdb_v;

  logic [N_ISSUE-1:0] w_grp1_hit;
  logic [N_ISSUE-1:0] w_grp2_hit;
  logic [TAG_W-1:0]   w_grp1_tag [N_ISSUE];
  logic [TAG_W-1:0]   w_grp2_tag [N_ISSUE];

  // Youngest earlier slot writing the same register supplies the tag
  always_comb begin
    for (int s = 0; s < N_ISSUE; s++) begin
      w_grp1_hit[s] = 1'b0;
      w_grp2_hit[s] = 1'b0;
      w_grp1_tag[s] = c_tag_none;
      w_grp2_tag[s] = c_tag_none;
      for (int j = 0; j < s; j++) begin
        if (iss_valid[j] && iss_rd[j*RW +: RW] == iss_rs1[s*RW +: RW]) begin
          w_grp1_hit[s] = 1'b1;
          w_grp1_tag[s] = iss_tag[j*TAG_W +: TAG_W];
        end
        if (iss_valid[j] && iss_rd[j*RW +: RW] == iss_rs2[s*RW +: RW]) begin
          w_grp2_hit[s] = 1'b1;
          w_grp2_tag[s] = iss_tag[j*TAG_W +: TAG_W];
        end
      end
    end
  end

  always_comb begin
    arch_d    = arch_q;
    dep_d     = dep_q;
    sval_d    = sval_q;
    srdy_d    = srdy_q;
    w_cdb_hit = 1'b0;
    w_cdb_v   = '0;
    for (int i = 1; i < NREG; i++) begin
      if (cmt_valid && cmt_rd == RW'(i)) begin
        arch_d[i] = cmt_val;
        if (cmt_tag != c_tag_none && dep_q[i] == cmt_tag) begin
          dep_d[i]  = c_tag_none;
          srdy_d[i] = 1'b0;
        end
      end
      w_cdb_hit = 1'b0;
      w_cdb_v   = '0;
      for (int c = N_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == dep_q[i]) begin
          w_cdb_hit = 1'b1;
          w_cdb_v   = cdb_val[c*XLEN +: XLEN];
        end
      end
      // First broadcast of the awaited tag is latched; later repeats are ignored
      if (dep_q[i] != c_tag_none && w_cdb_hit && !srdy_q[i]) begin
        sval_d[i] = w_cdb_v;
        srdy_d[i] = 1'b1;
      end
    end

    if (flush) begin
      for (int i = 0; i < NREG; i++) begin
        dep_d[i]  = c_tag_none;
        srdy_d[i] = 1'b0;
      end
    end else begin
      for (int s = 0; s < N_ISSUE; s++) begin
        if (iss_valid[s] && iss_rd[s*RW +: RW] != '0) begin
          dep_d[iss_rd[s*RW +: RW]]  = iss_tag[s*TAG_W +: TAG_W];
          srdy_d[iss_rd[s*RW +: RW]] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        arch_q[i] <= '0;
        dep_q[i]  <= c_tag_none;
        sval_q[i] <= '0;
      end
      srdy_q <= '0;
    end else if (rdy_in) begin
      arch_q <= arch_d;
      dep_q  <= dep_d;
      sval_q <= sval_d;
      srdy_q <= srdy_d;
    end
  end

  for (genvar s = 0; s < N_ISSUE; s++) begin : g_slot
    regfile_src_mux #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .N_CDB (N_CDB)
    ) u_src1 (
      .slot_valid_i (iss_valid[s]),
      .src_zero_i   (iss_rs1[s*RW +: RW] == '0),
      .grp_hit_i    (w_grp1_hit[s]),
      .grp_tag_i    (w_grp1_tag[s]),
      .dep_i        (dep_q[iss_rs1[s*RW +: RW]]),
      .spec_rdy_i   (srdy_q[iss_rs1[s*RW +: RW]]),
      .spec_val_i   (sval_q[iss_rs1[s*RW +: RW]]),
      .arch_i       (arch_q[iss_rs1[s*RW +: RW]]),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_val_i    (cdb_val),
      .cmt_valid_i  (cmt_valid),
      .cmt_tag_i    (cmt_tag),
      .cmt_val_i    (cmt_val),
      .v_o          (vj[s*XLEN +: XLEN]),
      .q_o          (qj[s*TAG_W +: TAG_W])
    );

    regfile_src_mux #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .N_CDB (N_CDB)
    ) u_src2 (
      .slot_valid_i (iss_valid[s]),
      .src_zero_i   (iss_rs2[s*RW +: RW] == '0),
      .grp_hit_i    (w_grp2_hit[s]),
      .grp_tag_i    (w_grp2_tag[s]),
      .dep_i        (dep_q[iss_rs2[s*RW +: RW]]),
      .spec_rdy_i   (srdy_q[iss_rs2[s*RW +: RW]]),
      .spec_val_i   (sval_q[iss_rs2[s*RW +: RW]]),
      .arch_i       (arch_q[iss_rs2[s*RW +: RW]]),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_val_i    (cdb_val),
      .cmt_valid_i  (cmt_valid),
      .cmt_tag_i    (cmt_tag),
      .cmt_val_i    (cmt_val),
      .v_o          (vk[s*XLEN +: XLEN]),
      .q_o          (qk[s*TAG_W +: TAG_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_rename.sv
// ============================================================================
// tb_regfile_rename : directed bench with a tag-table reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_rename;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int TW = 4;
  localparam int NI = 2;
  localparam int NC = 2;
  localparam int RW = 5;
  localparam int NT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic [NI-1:0]     iss_valid;
  logic [NI*RW-1:0]  iss_rd, iss_rs1, iss_rs2;
  logic [NI*TW-1:0]  iss_tag;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*XL-1:0]  cdb_val;
  logic              cmt_valid;
  logic [RW-1:0]     cmt_rd;
  logic [TW-1:0]     cmt_tag;
  logic [XL-1:0]     cmt_val;
  logic              flush;
  logic [NI*XL-1:0]  vj, vk;
  logic [NI*TW-1:0]  qj, qk;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_rename #(
    .XLEN(XL), .NREG(NR), .TAG_W(TW), .N_ISSUE(NI), .N_CDB(NC)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
    .flush(flush),
    .vj(vj), .vk(vk), .qj(qj), .qk(qk)
  );

  // Model: register -> awaited tag, plus a table of results seen per tag
  logic [XL-1:0] m_arch [NR];
  logic [TW-1:0] m_tag  [NR];
  bit            seen   [NT];
  logic [XL-1:0] tval   [NT];

  function automatic void mread(input int s, input logic [RW-1:0] r,
                                output logic [XL-1:0] v, output logic [TW-1:0] q);
    logic [TW-1:0] t;
    bit            grp;
    v = '0; q = '0; grp = 0;
    if (!iss_valid[s] || r == 0) return;
    for (int j = 0; j < s; j++)
      if (iss_valid[j] && iss_rd[j*RW +: RW] == r) begin
        grp = 1; q = iss_tag[j*TW +: TW];
      end
    if (grp) return;
    t = m_tag[r];
    if (t == 0) begin v = m_arch[r]; return; end
    if (seen[t]) begin v = tval[t]; return; end
    for (int c = 0; c < NC; c++)
      if (cdb_valid[c] && cdb_tag[c*TW +: TW] == t) begin v = cdb_val[c*XL +: XL]; return; end
    if (cmt_valid && cmt_tag == t) begin v = cmt_val; return; end
    q = t;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_arch[i] = '0; m_tag[i] = '0; end
      for (int t = 0; t < NT; t++) begin seen[t] = 0; tval[t] = '0; end
    end else if (rdy) begin
      if (cmt_valid && cmt_rd != 0) begin
        m_arch[cmt_rd] = cmt_val;
        if (cmt_tag != 0 && m_tag[cmt_rd] == cmt_tag) m_tag[cmt_rd] = '0;
      end
      for (int c = 0; c < NC; c++)
        if (cdb_valid[c] && cdb_tag[c*TW +: TW] != 0 && !seen[cdb_tag[c*TW +: TW]]) begin
          seen[cdb_tag[c*TW +: TW]] = 1;
          tval[cdb_tag[c*TW +: TW]] = cdb_val[c*XL +: XL];
        end
      if (flush) begin
        for (int i = 0; i < NR; i++) m_tag[i] = '0;
        for (int t = 0; t < NT; t++) seen[t] = 0;
      end else begin
        for (int s = 0; s < NI; s++)
          if (iss_valid[s] && iss_rd[s*RW +: RW] != 0) begin
            m_tag[iss_rd[s*RW +: RW]] = iss_tag[s*TW +: TW];
            seen[iss_tag[s*TW +: TW]] = 0;
          end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    rst = 0; rdy = 1; flush = 0;
    iss_valid = '0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; iss_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    cmt_valid = 0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
  endtask

  task automatic slot(input int s, input int rd, input int rs1, input int rs2, input int tag);
    iss_valid[s]        = 1'b1;
    iss_rd[s*RW +: RW]  = RW'(rd);
    iss_rs1[s*RW +: RW] = RW'(rs1);
    iss_rs2[s*RW +: RW] = RW'(rs2);
    iss_tag[s*TW +: TW] = TW'(tag);
  endtask

  task automatic cdb(input int c, input int tag, input logic [XL-1:0] val);
    cdb_valid[c]        = 1'b1;
    cdb_tag[c*TW +: TW] = TW'(tag);
    cdb_val[c*XL +: XL] = val;
  endtask

  task automatic cmt(input int rd, input int tag, input logic [XL-1:0] val);
    cmt_valid = 1'b1; cmt_rd = RW'(rd); cmt_tag = TW'(tag); cmt_val = val;
  endtask

  // Hand-computed expectation checked against both the DUT and the model
  task automatic lit(input string nm, input int s, input bit src2,
                     input logic [XL-1:0] ev, input logic [TW-1:0] eq);
    logic [XL-1:0] av, mv;
    logic [TW-1:0] aq, mq;
    av = src2 ? vk[s*XL +: XL] : vj[s*XL +: XL];
    aq = src2 ? qk[s*TW +: TW] : qj[s*TW +: TW];
    mread(s, src2 ? iss_rs2[s*RW +: RW] : iss_rs1[s*RW +: RW], mv, mq);
    checks++;
    if (av !== ev || aq !== eq) begin
      errors++;
      $display("FAIL %s dut: v=%h q=%0d expected v=%h q=%0d", nm, av, aq, ev, eq);
    end
    checks++;
    if (mv !== ev || mq !== eq) begin
      errors++;
      $display("FAIL %s model: v=%h q=%0d expected v=%h q=%0d", nm, mv, mq, ev, eq);
    end
  endtask

  // Every-cycle comparison of all operand outputs against the model
  initial begin
    logic [XL-1:0] ev1, ev2;
    logic [TW-1:0] eq1, eq2;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        for (int s = 0; s < NI; s++) begin
          mread(s, iss_rs1[s*RW +: RW], ev1, eq1);
          mread(s, iss_rs2[s*RW +: RW], ev2, eq2);
          checks++;
          if (vj[s*XL +: XL] !== ev1 || qj[s*TW +: TW] !== eq1 ||
              vk[s*XL +: XL] !== ev2 || qk[s*TW +: TW] !== eq2) begin
            errors++;
            $display("FAIL cycle slot%0d @%0t: vj=%h qj=%0d vk=%h qk=%0d expected vj=%h qj=%0d vk=%h qk=%0d",
                     s, $time, vj[s*XL +: XL], qj[s*TW +: TW], vk[s*XL +: XL], qk[s*TW +: TW],
                     ev1, eq1, ev2, eq2);
          end
        end
      end
    end
  end

  initial begin
    clr(); rst = 1;
    cyc(); cyc();

    // Reset state, then rename x5 -> tag 3
    clr(); slot(0, 5, 5, 0, 3);
    #2 lit("reset_x5", 0, 0, 32'h0, 4'd0);
    cyc();

    clr(); slot(0, 0, 5, 0, 0);
    #2 lit("pending_x5", 0, 0, 32'h0, 4'd3);
    cdb(1, 3, 32'hDEAD);
    #1 lit("cdb_bypass_x5", 0, 0, 32'hDEAD, 4'd0);
    cyc();

    clr(); slot(0, 0, 5, 0, 0);
    #2 lit("spec_x5", 0, 0, 32'hDEAD, 4'd0);
    cmt(5, 3, 32'hDEAD); slot(1, 0, 0, 5, 0);
    #1 lit("spec_during_cmt", 1, 1, 32'hDEAD, 4'd0);
    cyc();

    clr(); slot(0, 0, 5, 0, 0);
    #2 lit("arch_x5", 0, 0, 32'hDEAD, 4'd0);
    cyc();

    // Intra-group rename on x7
    clr(); slot(0, 7, 0, 0, 2); slot(1, 7, 7, 0, 4);
    #2 lit("grp_rename_x7", 1, 0, 32'h0, 4'd2);
    cyc();

    clr(); slot(0, 0, 7, 0, 0);
    #2 lit("youngest_x7", 0, 0, 32'h0, 4'd4);
    cdb(0, 4, 32'h111); cdb(1, 4, 32'h222);
    #1 lit("cdb_low_ch_wins", 0, 0, 32'h111, 4'd0);
    cyc();

    clr(); slot(0, 0, 7, 0, 0);
    #2 lit("spec_x7", 0, 0, 32'h111, 4'd0);
    cyc();

    // Commit and issue collide on x9
    clr(); slot(0, 9, 0, 0, 5);
    cyc();
    clr(); cmt(9, 5, 32'h11); slot(0, 9, 0, 0, 6); slot(1, 0, 9, 0, 0);
    #2 lit("grp_over_cmt_x9", 1, 0, 32'h0, 4'd6);
    cyc();
    clr(); slot(0, 0, 9, 0, 0);
    #2 lit("issue_wins_x9", 0, 0, 32'h0, 4'd6);
    cyc();

    // Flush with concurrent commit and discarded issue
    clr(); slot(0, 3, 0, 0, 1); slot(1, 4, 0, 0, 2);
    cyc();
    clr(); slot(0, 0, 3, 4, 0);
    #2 lit("pend_x3", 0, 0, 32'h0, 4'd1);
    lit("pend_x4", 0, 1, 32'h0, 4'd2);
    flush = 1; cmt(3, 1, 32'h77); slot(1, 4, 0, 0, 8);
    cyc();
    clr(); slot(0, 0, 3, 4, 0); slot(1, 0, 9, 7, 0);
    #2 lit("flush_cmt_x3", 0, 0, 32'h77, 4'd0);
    lit("flush_x4", 0, 1, 32'h0, 4'd0);
    lit("flush_arch_x9", 1, 0, 32'h11, 4'd0);
    lit("flush_spec_lost_x7", 1, 1, 32'h0, 4'd0);
    cyc();

    // Pause: nothing may change
    clr(); rdy = 0; slot(0, 10, 0, 0, 9); slot(1, 0, 10, 0, 0);
    cmt(10, 9, 32'h55); cdb(0, 9, 32'h66);
    #2 lit("pause_grp_x10", 1, 0, 32'h0, 4'd9);
    cyc();
    clr(); slot(0, 0, 10, 5, 0);
    #2 lit("pause_held_x10", 0, 0, 32'h0, 4'd0);
    lit("pause_held_x5", 0, 1, 32'hDEAD, 4'd0);
    cyc();

    // Register 0 stays zero
    clr(); slot(0, 0, 0, 0, 10); slot(1, 0, 0, 0, 0); cmt(0, 10, 32'hFFFF);
    #2 lit("x0_same_cycle", 1, 0, 32'h0, 4'd0);
    cyc();
    clr(); slot(0, 0, 0, 0, 0);
    #2 lit("x0_after", 0, 0, 32'h0, 4'd0);
    cyc();

    // Reset beats a concurrent issue
    clr(); slot(0, 11, 0, 0, 11); rst = 1;
    cyc();
    clr(); slot(0, 0, 11, 5, 0);
    #2 lit("rst_wins_x11", 0, 0, 32'h0, 4'd0);
    lit("rst_clears_x5", 0, 1, 32'h0, 4'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
